// File: rtl/input_conditioner_pkg.sv
// Shared types, clock/debounce defaults and sizing helper for the input conditioner.
package input_conditioner_pkg;

  localparam int DEFAULT_CLK_PERIOD_NS      = 20;
  localparam int DEFAULT_DEBOUNCE_TIMER_NS  = 30_000_000;

  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_FLIP  = 2'd2,
    ACT_HOLD  = 2'd3
  } deb_action_e;

  // A zero-width counter is illegal, so tiny debounce counts still get one bit.
  function automatic int cnt_width(input int deb_cnt);
    if (deb_cnt < 1) begin
      return 1;
    end else begin
      return $clog2(deb_cnt + 1);
    end
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: polarity, synchroniser, debounce counter, edge pulses and sticky event.
module conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CNT     = 5,
  parameter int   CNT_W       = 3,
  parameter logic INVERT      = 1'b0,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic flag
);

  localparam logic [CNT_W-1:0] LAST_CNT = (DEB_CNT > 1) ? CNT_W'(DEB_CNT - 1) : {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   rise_r;
  logic                   rise_nxt_s;
  logic                   fall_r;
  logic                   fall_nxt_s;
  logic                   flag_r;
  logic                   flag_nxt_s;
  logic                   sync_out_s;
  deb_action_e            act_s;

  assign sync_out_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain, inversion applied before the first flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw ^ INVERT};
    end
  end

  // Debounce decision; agreement restarts the count even while sampling is paused.
  always_comb begin
    act_s = ACT_CLEAR;
    if (sync_out_s == level_r) begin
      act_s = ACT_CLEAR;
    end else if (!enable) begin
      act_s = ACT_HOLD;
    end else if (cnt_r == LAST_CNT) begin
      act_s = ACT_FLIP;
    end else begin
      act_s = ACT_COUNT;
    end
  end

  // Next-state values for counter, level, edge pulses and sticky flag.
  always_comb begin
    cnt_nxt_s   = {CNT_W{1'b0}};
    level_nxt_s = level_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (act_s)
      ACT_CLEAR: cnt_nxt_s = {CNT_W{1'b0}};
      ACT_COUNT: cnt_nxt_s = cnt_r + CNT_W'(1);
      ACT_HOLD:  cnt_nxt_s = cnt_r;
      ACT_FLIP: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        level_nxt_s = sync_out_s;
        rise_nxt_s  = sync_out_s;
        fall_nxt_s  = ~sync_out_s;
      end
      default: cnt_nxt_s = {CNT_W{1'b0}};
    endcase
    // A rise in the same cycle as a clear keeps the flag set.
    flag_nxt_s = rise_nxt_s | (flag_r & ~clr);
  end

  // Debounce and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= INIT_LEVEL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      flag_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      flag_r  <= flag_nxt_s;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;
  assign flag  = flag_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch/button front end; sizes the debounce counter and replicates the channel.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                 CHANNELS          = 8,
  parameter int                 SYNC_STAGES       = 2,
  parameter int                 CLK_PERIOD_ns     = DEFAULT_CLK_PERIOD_NS,
  parameter int                 DEBOUNCE_TIMER_ns = DEFAULT_DEBOUNCE_TIMER_NS,
  parameter logic [CHANNELS-1:0] INVERT_MASK      = {CHANNELS{1'b0}},
  parameter logic [CHANNELS-1:0] INIT_LEVEL       = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [CHANNELS-1:0] event_clr,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] event_o
);

  localparam int DEB_CNT = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns;
  localparam int CNT_W   = cnt_width(DEB_CNT);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    conditioner_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT     (DEB_CNT),
      .CNT_W       (CNT_W),
      .INVERT      (INVERT_MASK[i]),
      .INIT_LEVEL  (INIT_LEVEL[i])
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .raw    (raw_i[i]),
      .clr    (event_clr[i]),
      .level  (level_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i]),
      .flag   (event_o[i])
    );
  end

endmodule
